// File: rtl/chaos_xor_decrypt.sv
// rtl/chaos_xor_decrypt.sv - logistic/tent chaotic keystream XOR decryptor
// One shift-add multiplier computes 4x(1-x) per word; the tent map mixes in a rotated x'.
module chaos_xor_decrypt #(
   parameter logic [31:0] X_SEED   = 32'h6B851EB8,
   parameter logic [31:0] Y_SEED   = 32'hD6C8B439,
   parameter logic [31:0] ZERO_SUB = 32'h5A5A5A5A
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        seed_load,
   input  logic [31:0] seed_x,
   input  logic [31:0] seed_y,
   input  logic [31:0] cin_data,
   input  logic        cin_valid,
   output logic        cin_ready,
   output logic [31:0] pout_data,
   output logic        pout_valid,
   input  logic        pout_ready,
   output logic [15:0] word_count,
   output logic        busy
);

   typedef enum logic [2:0] {S_LOAD, S_MUL, S_UPD, S_READY, S_OUT} state_t;

   state_t      state, state_nx;
   logic [31:0] x_q, y_q, k_q;
   logic [61:0] acc_q, mcand_q;
   logic [31:0] mplier_q;
   logic [4:0]  bit_cnt;
   logic [15:0] wc_q;
   logic [31:0] x_raw, x_new, t_val, y_new;
   logic        in_fire, out_fire;
   logic        unused_acc_low;

   assign cin_ready  = (state == S_READY) && !seed_load;
   assign pout_valid = (state == S_OUT);
   assign busy       = (state == S_LOAD) || (state == S_MUL) || (state == S_UPD);
   assign word_count = wc_q;
   assign in_fire    = cin_valid && cin_ready;
   assign out_fire   = pout_valid && pout_ready && !seed_load;

   // The product never exceeds 2^62, so a 62-bit accumulator holds it exactly.
   assign x_raw          = acc_q[61:30];
   assign unused_acc_low = ^acc_q[29:0];
   assign x_new          = (x_raw == 32'd0) ? ZERO_SUB : x_raw;
   assign t_val          = y_q[31] ? {~y_q[30:0], 1'b0} : {y_q[30:0], 1'b0};
   assign y_new          = t_val ^ {x_new[15:0], x_new[31:16]};

   always_comb begin
      state_nx = state;
      case (state)
         S_LOAD:  state_nx = S_MUL;
         S_MUL:   if (bit_cnt == 5'd31) state_nx = S_UPD;
         S_UPD:   state_nx = S_READY;
         S_READY: if (in_fire) state_nx = S_OUT;
         S_OUT:   if (out_fire) state_nx = S_LOAD;
         default: state_nx = S_LOAD;
      endcase
      if (seed_load) state_nx = S_LOAD;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_LOAD;
         x_q       <= X_SEED;
         y_q       <= Y_SEED;
         k_q       <= 32'd0;
         acc_q     <= 62'd0;
         mcand_q   <= 62'd0;
         mplier_q  <= 32'd0;
         bit_cnt   <= 5'd0;
         pout_data <= 32'd0;
         wc_q      <= 16'd0;
      end else begin
         state <= state_nx;
         if (seed_load) begin
            x_q  <= seed_x;
            y_q  <= seed_y;
            wc_q <= 16'd0;
         end else begin
            case (state)
               S_LOAD: begin
                  mcand_q  <= {30'd0, x_q};
                  mplier_q <= ~x_q;
                  acc_q    <= 62'd0;
                  bit_cnt  <= 5'd0;
               end
               S_MUL: begin
                  if (mplier_q[0]) acc_q <= acc_q + mcand_q;
                  mcand_q  <= mcand_q << 1;
                  mplier_q <= mplier_q >> 1;
                  bit_cnt  <= bit_cnt + 5'd1;
               end
               S_UPD: begin
                  x_q <= x_new;
                  y_q <= y_new;
                  k_q <= x_new ^ y_new;
               end
               S_READY: if (in_fire) pout_data <= cin_data ^ k_q;
               S_OUT:   if (out_fire) wc_q <= wc_q + 16'd1;
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_chaos_xor_decrypt.sv
// tb/tb_chaos_xor_decrypt.sv - scoreboard bench for chaos_xor_decrypt
module tb_chaos_xor_decrypt;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        seed_load = 1'b0;
   logic [31:0] seed_x = 32'd0, seed_y = 32'd0;
   logic [31:0] cin_data = 32'd0;
   logic        cin_valid = 1'b0;
   logic        cin_ready;
   logic [31:0] pout_data;
   logic        pout_valid;
   logic        pout_ready = 1'b0;
   logic [15:0] word_count;
   logic        busy;

   logic        rt_seed = 1'b0;
   logic [31:0] rt_seed_x = 32'd0, rt_seed_y = 32'd0;
   logic [31:0] a_cin_data = 32'd0;
   logic        a_cin_valid = 1'b0, a_cin_ready;
   logic [31:0] ab_data;
   logic        ab_valid, ab_ready;
   logic [15:0] a_word_count, b_word_count;
   logic        a_busy, b_busy;
   logic [31:0] b_pout_data;
   logic        b_pout_valid, b_pout_ready = 1'b0;

   int vec = 0;
   int errs = 0;
   logic [31:0] mx, my;
   logic [31:0] exp_q[$];
   logic [31:0] rt_q[$];

   always #5 clk = ~clk;

   chaos_xor_decrypt dut (
      .clk(clk), .reset(reset), .seed_load(seed_load), .seed_x(seed_x), .seed_y(seed_y),
      .cin_data(cin_data), .cin_valid(cin_valid), .cin_ready(cin_ready),
      .pout_data(pout_data), .pout_valid(pout_valid), .pout_ready(pout_ready),
      .word_count(word_count), .busy(busy));

   chaos_xor_decrypt u_a (
      .clk(clk), .reset(reset), .seed_load(rt_seed), .seed_x(rt_seed_x), .seed_y(rt_seed_y),
      .cin_data(a_cin_data), .cin_valid(a_cin_valid), .cin_ready(a_cin_ready),
      .pout_data(ab_data), .pout_valid(ab_valid), .pout_ready(ab_ready),
      .word_count(a_word_count), .busy(a_busy));

   chaos_xor_decrypt u_b (
      .clk(clk), .reset(reset), .seed_load(rt_seed), .seed_x(rt_seed_x), .seed_y(rt_seed_y),
      .cin_data(ab_data), .cin_valid(ab_valid), .cin_ready(ab_ready),
      .pout_data(b_pout_data), .pout_valid(b_pout_valid), .pout_ready(b_pout_ready),
      .word_count(b_word_count), .busy(b_busy));

   // Reference keystream step: returns {x', y', k}.
   function automatic logic [95:0] ks_step(input logic [31:0] x, input logic [31:0] y);
      logic [63:0] p;
      logic [31:0] xn, t, yn;
      p  = {32'd0, x} * {32'd0, ~x};
      xn = p[61:30];
      if (xn == 32'd0) xn = 32'h5A5A5A5A;
      t  = (y < 32'h80000000) ? (y << 1) : ((~y) << 1);
      yn = t ^ {xn[15:0], xn[31:16]};
      return {xn, yn, xn ^ yn};
   endfunction

   task automatic push_expected(input logic [31:0] w);
      logic [95:0] r;
      r  = ks_step(mx, my);
      mx = r[95:64];
      my = r[63:32];
      exp_q.push_back(w ^ r[31:0]);
   endtask

   task automatic pop_expected(output logic [31:0] e);
      if (exp_q.size() == 0) e = 32'hxxxxxxxx;
      else e = exp_q.pop_front();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      mx = 32'h6B851EB8;
      my = 32'hD6C8B439;
      exp_q.delete();
   endtask

   task automatic seed_pulse(input logic [31:0] sx, input logic [31:0] sy);
      seed_x = sx; seed_y = sy; seed_load = 1'b1;
      @(negedge clk);
      seed_load = 1'b0;
      mx = sx; my = sy;
      exp_q.delete();
   endtask

   task automatic send(input logic [31:0] w, output bit ok);
      int n;
      n = 0;
      cin_data = w; cin_valid = 1'b1;
      while (!cin_ready && n < 300) begin @(negedge clk); n++; end
      ok = cin_ready;
      if (ok) push_expected(w);
      @(negedge clk);
      cin_valid = 1'b0;
   endtask

   task automatic recv(output logic [31:0] d, output bit ok);
      int n;
      n = 0;
      pout_ready = 1'b1;
      while (!pout_valid && n < 300) begin @(negedge clk); n++; end
      ok = pout_valid;
      d = pout_data;
      @(negedge clk);
      pout_ready = 1'b0;
   endtask

   task automatic test_reset();
      logic [31:0] e;
      pout_ready = 1'b0;
      cin_data = 32'hA5A50F0F; cin_valid = 1'b1;
      do_reset();
      vec++; if (cin_ready !== 1'b0) begin errs++; $display("FAIL reset_cin_ready: got %b expected 0", cin_ready); end
      vec++; if (busy !== 1'b1) begin errs++; $display("FAIL reset_busy: got %b expected 1", busy); end
      vec++; if (pout_valid !== 1'b0) begin errs++; $display("FAIL reset_pout_valid: got %b expected 0", pout_valid); end
      vec++; if (pout_data !== 32'd0) begin errs++; $display("FAIL reset_pout_data: got %h expected 0", pout_data); end
      vec++; if (word_count !== 16'd0) begin errs++; $display("FAIL reset_word_count: got %h expected 0", word_count); end
      for (int c = 1; c <= 34; c++) begin
         @(negedge clk);
         vec++;
         if (cin_ready !== (c == 34)) begin
            errs++; $display("FAIL reset_ready_cycle%0d: got %b expected %b", c, cin_ready, (c == 34));
         end
      end
      push_expected(cin_data);
      @(negedge clk);
      cin_valid = 1'b0;
      pop_expected(e);
      vec++; if (pout_valid !== 1'b1) begin errs++; $display("FAIL first_pout_valid_c35: got %b expected 1", pout_valid); end
      vec++; if (pout_data !== e) begin errs++; $display("FAIL first_pout_data: got %h expected %h", pout_data, e); end
      pout_ready = 1'b1;
      @(negedge clk);
      pout_ready = 1'b0;
      vec++; if (word_count !== 16'd1) begin errs++; $display("FAIL first_word_count: got %h expected 1", word_count); end
      vec++; if (busy !== 1'b1) begin errs++; $display("FAIL busy_after_out: got %b expected 1", busy); end
   endtask

   task automatic test_words(input string name, input logic [31:0] sx, input logic [31:0] sy,
                             input logic [31:0] w0, input int count);
      logic [31:0] d, e;
      bit ok;
      seed_pulse(sx, sy);
      for (int i = 0; i < count; i++) begin
         send(w0 + 32'h01234567 * i, ok);
         recv(d, ok);
         pop_expected(e);
         vec++;
         if (!ok || d !== e) begin errs++; $display("FAIL %s_word%0d: got %h expected %h", name, i, d, e); end
      end
      vec++;
      if (word_count !== 16'(count)) begin
         errs++; $display("FAIL %s_word_count: got %h expected %h", name, word_count, 16'(count));
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] d0, e;
      logic [15:0] wc0;
      bit ok;
      int n;
      seed_pulse(32'h13579BDF, 32'h2468ACE0);
      send(32'hDEADBEEF, ok);
      n = 0;
      while (!pout_valid && n < 300) begin @(negedge clk); n++; end
      d0 = pout_data; wc0 = word_count;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         vec++;
         if (pout_valid !== 1'b1 || pout_data !== d0 || cin_ready !== 1'b0 || word_count !== wc0) begin
            errs++;
            $display("FAIL backpressure_c%0d: got v=%b d=%h r=%b wc=%h expected v=1 d=%h r=0 wc=%h",
                     c, pout_valid, pout_data, cin_ready, word_count, d0, wc0);
         end
      end
      pop_expected(e);
      vec++; if (d0 !== e) begin errs++; $display("FAIL backpressure_data: got %h expected %h", d0, e); end
      pout_ready = 1'b1;
      @(negedge clk);
      pout_ready = 1'b0;
      vec++; if (word_count !== wc0 + 16'd1) begin errs++; $display("FAIL backpressure_wc: got %h expected %h", word_count, wc0 + 16'd1); end
   endtask

   task automatic test_seed_in_ready();
      logic [31:0] d, e;
      bit ok;
      int n;
      test_words("pre_ready", 32'h31415926, 32'h27182818, 32'h11111111, 1);
      n = 0;
      while (!cin_ready && n < 300) begin @(negedge clk); n++; end
      cin_data = 32'hCAFEF00D; cin_valid = 1'b1;
      seed_x = 32'h0F0F0F0F; seed_y = 32'hF0F0F0F0; seed_load = 1'b1;
      #1;
      vec++; if (cin_ready !== 1'b0) begin errs++; $display("FAIL seed_ready_masks: got %b expected 0", cin_ready); end
      @(negedge clk);
      seed_load = 1'b0; cin_valid = 1'b0;
      mx = 32'h0F0F0F0F; my = 32'hF0F0F0F0; exp_q.delete();
      vec++; if (pout_valid !== 1'b0) begin errs++; $display("FAIL seed_ready_no_accept: got %b expected 0", pout_valid); end
      vec++; if (word_count !== 16'd0) begin errs++; $display("FAIL seed_ready_wc: got %h expected 0", word_count); end
      for (int c = 1; c <= 34; c++) begin
         @(negedge clk);
         vec++;
         if (cin_ready !== (c == 34)) begin
            errs++; $display("FAIL seed_restart_cycle%0d: got %b expected %b", c, cin_ready, (c == 34));
         end
      end
      send(32'h76543210, ok);
      recv(d, ok);
      pop_expected(e);
      vec++; if (!ok || d !== e) begin errs++; $display("FAIL seed_ready_fresh: got %h expected %h", d, e); end
   endtask

   task automatic test_seed_in_out();
      logic [31:0] d, e;
      bit ok;
      int n;
      test_words("pre_out", 32'h55AA55AA, 32'h01020304, 32'h22222222, 1);
      send(32'h89ABCDEF, ok);
      n = 0;
      while (!pout_valid && n < 300) begin @(negedge clk); n++; end
      seed_x = 32'h9E3779B9; seed_y = 32'h7F4A7C15; seed_load = 1'b1; pout_ready = 1'b1;
      @(negedge clk);
      seed_load = 1'b0; pout_ready = 1'b0;
      mx = 32'h9E3779B9; my = 32'h7F4A7C15; exp_q.delete();
      vec++; if (pout_valid !== 1'b0) begin errs++; $display("FAIL seed_out_discard: got %b expected 0", pout_valid); end
      vec++; if (word_count !== 16'd0) begin errs++; $display("FAIL seed_out_wc: got %h expected 0", word_count); end
      send(32'h0BADC0DE, ok);
      recv(d, ok);
      pop_expected(e);
      vec++; if (!ok || d !== e) begin errs++; $display("FAIL seed_out_fresh: got %h expected %h", d, e); end
      vec++; if (word_count !== 16'd1) begin errs++; $display("FAIL seed_out_wc_after: got %h expected 1", word_count); end
   endtask

   task automatic test_wrap();
      logic [31:0] d, e;
      bit ok;
      force dut.wc_q = 16'hFFFF;
      #1;
      release dut.wc_q;
      @(negedge clk);
      vec++; if (word_count !== 16'hFFFF) begin errs++; $display("FAIL wrap_preload: got %h expected ffff", word_count); end
      send(32'h12345678, ok);
      recv(d, ok);
      pop_expected(e);
      vec++; if (!ok || d !== e) begin errs++; $display("FAIL wrap_data: got %h expected %h", d, e); end
      vec++; if (word_count !== 16'd0) begin errs++; $display("FAIL wrap_to_zero: got %h expected 0", word_count); end
   endtask

   task automatic test_round_trip();
      bit abort;
      int got;
      abort = 1'b0;
      got = 0;
      rt_q.delete();
      rt_seed_x = 32'h2545F491; rt_seed_y = 32'h4F6CDD1D; rt_seed = 1'b1;
      @(negedge clk);
      rt_seed = 1'b0;
      fork
         begin
            for (int i = 0; i < 1000 && !abort; i++) begin
               int st, n;
               logic [31:0] w;
               st = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
               repeat (st) @(negedge clk);
               w = $urandom;
               a_cin_data = w; a_cin_valid = 1'b1;
               n = 0;
               while (!a_cin_ready && n < 500) begin @(negedge clk); n++; end
               if (!a_cin_ready) begin
                  vec++; errs++; abort = 1'b1;
                  $display("FAIL rt_source_timeout: got ready=0 expected ready=1 at word %0d", i);
               end else rt_q.push_back(w);
               @(negedge clk);
               a_cin_valid = 1'b0;
            end
         end
         begin
            int idle;
            logic [31:0] e;
            idle = 0;
            while (got < 1000 && idle < 2000) begin
               b_pout_ready = ($urandom_range(0, 3) != 0);
               if (b_pout_valid && b_pout_ready) begin
                  e = (rt_q.size() != 0) ? rt_q.pop_front() : 32'hxxxxxxxx;
                  vec++;
                  if (b_pout_data !== e) begin
                     errs++; $display("FAIL rt_word%0d: got %h expected %h", got, b_pout_data, e);
                  end
                  got++; idle = 0;
               end else idle++;
               @(negedge clk);
            end
            b_pout_ready = 1'b0;
         end
      join
      vec++; if (got != 1000) begin errs++; $display("FAIL rt_count: got %0d expected 1000", got); end
      vec++; if (b_word_count !== 16'd1000) begin errs++; $display("FAIL rt_b_word_count: got %0d expected 1000", b_word_count); end
      vec++; if (a_word_count !== 16'd1000) begin errs++; $display("FAIL rt_a_word_count: got %0d expected 1000", a_word_count); end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_words("known_seed", 32'h80000000, 32'h40000000, 32'h80000001, 2);
      test_words("zero_seed", 32'h00000000, 32'h12345678, 32'hFFFF0000, 3);
      test_words("ones_seed", 32'hFFFFFFFF, 32'h87654321, 32'h0000FFFF, 3);
      test_words("stream", 32'h6B851EB8, 32'hD6C8B439, 32'hA0A0A0A0, 4);
      test_backpressure();
      test_seed_in_ready();
      test_seed_in_out();
      test_wrap();
      test_round_trip();
      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end

endmodule
